// File: rtl/spi_pkg.sv
// Shared SPI definitions: the FSM state type plus the default timing constants
// used by the ADC master, the SPI slave and the DAC driver.
package spi_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spi_state_t;

    localparam int          SPI_CLK_DIV       = 20;
    localparam int          SPI_FRAME_BITS    = 16;
    localparam int          SPI_DATA_BITS     = 10;
    localparam logic [15:0] ADC_CMD           = 16'hD000;
    localparam int          ADC_SAMPLE_PERIOD = 40000;

endpackage

// File: rtl/adc_spi_master_if.sv
// SPI pin bundle between an initiator (drives sck/cs_n/mosi) and a target (drives miso).
interface adc_spi_master_if;

    logic sck;
    logic cs_n;
    logic mosi;
    logic miso;

    modport master (output sck, output cs_n, output mosi, input miso);
    modport slave  (input sck, input cs_n, input mosi, output miso);

endinterface

// File: rtl/sck_tick_gen.sv
// sck half-period divider: free-runs 0..CLK_DIV-1 while run is high, parked at 0 otherwise.
module sck_tick_gen #(
    parameter int CLK_DIV = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int               DIV_W   = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values that existed before the clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              div <= '0;
        else if (!run)           div <= '0;
        else if (div == DIV_MAX) div <= '0;
        else                     div <= div + 1'b1;
    end

    assign tick = (div == DIV_MAX);

endmodule

// File: rtl/adc_spi_master.sv
// SPI mode-0 initiator that periodically reads one frame from a serial ADC and
// presents the low DATA_BITS bits as a sample with a one-cycle valid strobe.
module adc_spi_master
    import spi_pkg::*;
#(
    parameter int                    CLK_DIV       = SPI_CLK_DIV,
    parameter int                    FRAME_BITS    = SPI_FRAME_BITS,
    parameter int                    DATA_BITS     = SPI_DATA_BITS,
    parameter logic [FRAME_BITS-1:0] CMD           = FRAME_BITS'(ADC_CMD),
    parameter int                    SAMPLE_PERIOD = ADC_SAMPLE_PERIOD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    adc_spi_master_if.master     spi,
    output logic [DATA_BITS-1:0] sample,
    output logic                 valid,
    output logic                 busy
);

    localparam int               TMR_W    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);
    localparam int               CNT_W    = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_BITS - 1);

    spi_state_t            state, state_d;
    logic [TMR_W-1:0]      timer;
    logic                  req, pend, tick;
    logic                  sck_q, sck_d, cs_n_q, cs_n_d, mosi_q, mosi_d, valid_d;
    logic [CNT_W-1:0]      bitcnt, bitcnt_d;
    logic [FRAME_BITS-1:0] tx, tx_d, rx, rx_d;
    logic [DATA_BITS-1:0]  sample_d;

    // Period timer is parked at 0 while disabled, so the first request lands a full period after en rises.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         timer <= '0;
        else if (!en || timer == TMR_LAST)  timer <= '0;
        else                                timer <= timer + 1'b1;
    end

    assign req  = en && (timer == TMR_LAST);
    assign busy = (state != IDLE);

    sck_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .reset(reset),
        .run  (busy),
        .tick (tick)
    );

    // NOTE: every signal written here is given its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state;
        sck_d    = sck_q;
        cs_n_d   = cs_n_q;
        mosi_d   = mosi_q;
        bitcnt_d = bitcnt;
        tx_d     = tx;
        rx_d     = rx;
        sample_d = sample;
        valid_d  = 1'b0;
        case (state)
            IDLE: if (req || pend) begin
                cs_n_d   = 1'b0;
                mosi_d   = CMD[FRAME_BITS-1];
                tx_d     = CMD << 1;
                bitcnt_d = '0;
                state_d  = SETUP;
            end
            SETUP: if (tick) begin
                sck_d   = 1'b1;
                rx_d    = (rx << 1) | FRAME_BITS'(spi.miso);
                state_d = SHIFT;
            end
            SHIFT: if (tick) begin
                sck_d = ~sck_q;
                if (!sck_q) begin
                    rx_d = (rx << 1) | FRAME_BITS'(spi.miso);
                end else if (bitcnt != BIT_LAST) begin
                    bitcnt_d = bitcnt + 1'b1;
                    mosi_d   = tx[FRAME_BITS-1];
                    tx_d     = tx << 1;
                end else begin
                    cs_n_d   = 1'b1;
                    mosi_d   = 1'b0;
                    sample_d = rx[DATA_BITS-1:0];
                    valid_d  = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pins are driven straight from flops so reset forces cs_n high and sck low asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            sck_q  <= 1'b0;
            cs_n_q <= 1'b1;
            mosi_q <= 1'b0;
            bitcnt <= '0;
            tx     <= '0;
            rx     <= '0;
            sample <= '0;
            valid  <= 1'b0;
            pend   <= 1'b0;
        end else begin
            state  <= state_d;
            sck_q  <= sck_d;
            cs_n_q <= cs_n_d;
            mosi_q <= mosi_d;
            bitcnt <= bitcnt_d;
            tx     <= tx_d;
            rx     <= rx_d;
            sample <= sample_d;
            valid  <= valid_d;
            // A request landing on the HOLD->IDLE cycle is carried one cycle into IDLE.
            pend   <= req && (state == HOLD) && tick;
        end
    end

    assign spi.sck  = sck_q;
    assign spi.cs_n = cs_n_q;
    assign spi.mosi = mosi_q;

    // Any other request arriving mid-frame is dropped; a legal SAMPLE_PERIOD never produces one.
    assert property (@(posedge clk) disable iff (!reset)
        !(req && busy && !(state == HOLD && tick)));

endmodule
